// File: rtl/dual_queue_credit_drain.sv
// Consumer end of a credit-managed two-channel link: two no-backpressure queues merged
// round-robin onto one ready/valid output, with one credit pulse returned per dequeue.
module dual_queue_credit_drain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             q0_enq_valid,
  input  logic [WIDTH-1:0] q0_enq_bits,
  input  logic             q1_enq_valid,
  input  logic [WIDTH-1:0] q1_enq_bits,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_bits,
  output logic             deq_src,
  output logic             q0_credit,
  output logic             q1_credit,
  output logic [1:0]       overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PtrW-1:0]  rptr_q [2];
  logic [PtrW-1:0]  rptr_d [2];
  logic [PtrW-1:0]  wptr_q [2];
  logic [PtrW-1:0]  wptr_d [2];
  logic [CntW-1:0]  count_q [2];
  logic [CntW-1:0]  count_d [2];
  logic [WIDTH-1:0] enq_bits [2];

  logic [1:0] enq_valid;
  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push_ok;
  logic [1:0] pop;

  logic       grant;
  logic       fire;
  logic       last_q, last_d;
  logic       lock_q, lock_d;
  logic       locked_src_q, locked_src_d;
  logic [1:0] credit_q, credit_d;
  logic [1:0] overflow_q, overflow_d;

  assign enq_valid   = {q1_enq_valid, q0_enq_valid};
  assign enq_bits[0] = q0_enq_bits;
  assign enq_bits[1] = q1_enq_bits;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]  = (count_q[i] == CntFull);
      empty[i] = (count_q[i] == '0);
    end
  end

  // A stalled output stays locked to its source so data never changes under a waiting sink.
  always_comb begin
    if (lock_q) begin
      grant = locked_src_q;
    end else if (!empty[0] && !empty[1]) begin
      grant = ~last_q;
    end else begin
      grant = empty[0] & ~empty[1];
    end
  end

  assign deq_valid = ~empty[grant];
  assign deq_bits  = mem_q[grant][rptr_q[grant]];
  assign deq_src   = grant;
  assign fire      = deq_valid & deq_ready;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // A push into a full queue is dropped even if that queue pops this cycle.
      push_ok[i] = enq_valid[i] & ~full[i];
      pop[i]     = fire & (grant == 1'(i));
      wptr_d[i]  = push_ok[i] ? wptr_q[i] + PtrW'(1) : wptr_q[i];
      rptr_d[i]  = pop[i] ? rptr_q[i] + PtrW'(1) : rptr_q[i];
      count_d[i] = count_q[i] + CntW'(push_ok[i]) - CntW'(pop[i]);
    end
    overflow_d   = overflow_q | (enq_valid & full);
    credit_d     = pop;
    last_d       = fire ? grant : last_q;
    lock_d       = lock_q;
    locked_src_d = locked_src_q;
    if (fire) begin
      lock_d = 1'b0;
    end else if (deq_valid) begin
      lock_d       = 1'b1;
      locked_src_d = grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rptr_q[i]  <= '0;
        wptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      last_q       <= 1'b1;
      lock_q       <= 1'b0;
      locked_src_q <= 1'b0;
      credit_q     <= '0;
      overflow_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rptr_q[i]  <= rptr_d[i];
        wptr_q[i]  <= wptr_d[i];
        count_q[i] <= count_d[i];
      end
      last_q       <= last_d;
      lock_q       <= lock_d;
      locked_src_q <= locked_src_d;
      credit_q     <= credit_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset && push_ok[i]) begin
        mem_q[i][wptr_q[i]] <= enq_bits[i];
      end
    end
  end

  assign q0_credit = credit_q[0];
  assign q1_credit = credit_q[1];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dual_queue_credit_drain.sv
// Scoreboard bench: expected entries are queued as pushes are driven and retired on each fire.
module tb_dual_queue_credit_drain;

  typedef struct packed {
    logic        src;
    logic [31:0] bits;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        q0_enq_valid, q1_enq_valid;
  logic [31:0] q0_enq_bits, q1_enq_bits;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_bits;
  logic        deq_src;
  logic        q0_credit, q1_credit;
  logic [1:0]  overflow;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_c0 = 1'b0;
  logic exp_c1 = 1'b0;

  dual_queue_credit_drain #(.WIDTH(32), .DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .q0_enq_valid(q0_enq_valid),
    .q0_enq_bits (q0_enq_bits),
    .q1_enq_valid(q1_enq_valid),
    .q1_enq_bits (q1_enq_bits),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_bits    (deq_bits),
    .deq_src     (deq_src),
    .q0_credit   (q0_credit),
    .q1_credit   (q1_credit),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  // Retire one scoreboard entry per fire; credits must follow one cycle later.
  always @(negedge clock) begin
    exp_t e;
    checks++;
    if (q0_credit !== exp_c0 || q1_credit !== exp_c1) begin
      errors++;
      $display("FAIL credit: got %b%b expected %b%b", q1_credit, q0_credit, exp_c1, exp_c0);
    end
    exp_c0 = 1'b0;
    exp_c1 = 1'b0;
    if (!reset && deq_valid === 1'b1 && deq_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fire: got src %b bits %0h expected none", deq_src, deq_bits);
      end else begin
        e = sb.pop_front();
        if (deq_src !== e.src || deq_bits !== e.bits) begin
          errors++;
          $display("FAIL deq_order: got src %b bits %0h expected src %b bits %0h",
                   deq_src, deq_bits, e.src, e.bits);
        end
        exp_c0 = (e.src == 1'b0);
        exp_c1 = (e.src == 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (deq_valid !== 1'b0 || deq_src !== 1'b0 || q0_credit !== 1'b0 || q1_credit !== 1'b0
        || overflow !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got v%b s%b c%b%b ov%b expected v0 s0 c00 ov00",
               deq_valid, deq_src, q1_credit, q0_credit, overflow);
    end
  endtask

  task automatic test_single();
    apply_reset();
    deq_ready = 1'b1;
    q0_enq_valid = 1'b1;
    q0_enq_bits = 32'hA0;
    sb.push_back('{src: 1'b0, bits: 32'hA0});
    tick();
    q0_enq_valid = 1'b0;
    checks++;
    if (deq_valid !== 1'b1 || deq_bits !== 32'hA0 || deq_src !== 1'b0) begin
      errors++;
      $display("FAIL single_out: got v%b bits %0h s%b expected v1 bits a0 s0",
               deq_valid, deq_bits, deq_src);
    end
    tick();
    checks++;
    if (q0_credit !== 1'b1 || q1_credit !== 1'b0 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL single_credit: got c%b%b ov%b expected c01 ov00",
               q1_credit, q0_credit, overflow);
    end
    tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0_enq_valid = 1'b1;
      q1_enq_valid = 1'b1;
      q0_enq_bits = 32'h10 + i;
      q1_enq_bits = 32'h20 + i;
      sb.push_back('{src: 1'b0, bits: 32'h10 + i});
      sb.push_back('{src: 1'b1, bits: 32'h20 + i});
      tick();
    end
    q0_enq_valid = 1'b0;
    q1_enq_valid = 1'b0;
    tick();
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (deq_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_valid: got %b expected 1 at beat %0d", deq_valid, i);
      end
      tick();
    end
    checks++;
    if (deq_valid !== 1'b0 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL rr_drained: got v%b ov%b expected v0 ov00", deq_valid, overflow);
    end
    deq_ready = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    apply_reset();
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q1_enq_valid = 1'b1;
      q1_enq_bits = 32'h30 + i;
      if (i < 4) sb.push_back('{src: 1'b1, bits: 32'h30 + i});
      tick();
    end
    q1_enq_valid = 1'b0;
    checks++;
    if (overflow !== 2'b10) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 10", overflow);
    end
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (deq_valid !== 1'b1) begin
        errors++;
        $display("FAIL ovf_drain: got %b expected 1 at beat %0d", deq_valid, i);
      end
      tick();
    end
    checks++;
    if (deq_valid !== 1'b0 || overflow !== 2'b10) begin
      errors++;
      $display("FAIL ovf_after: got v%b ov%b expected v0 ov10", deq_valid, overflow);
    end
    deq_ready = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    apply_reset();
    deq_ready = 1'b0;
    q1_enq_valid = 1'b1;
    q1_enq_bits = 32'h40;
    sb.push_back('{src: 1'b1, bits: 32'h40});
    tick();
    q1_enq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (deq_valid !== 1'b1 || deq_src !== 1'b1 || deq_bits !== 32'h40) begin
        errors++;
        $display("FAIL stall_hold: got v%b s%b bits %0h expected v1 s1 bits 40",
                 deq_valid, deq_src, deq_bits);
      end
      tick();
    end
    q0_enq_valid = 1'b1;
    q0_enq_bits = 32'h50;
    sb.push_back('{src: 1'b0, bits: 32'h50});
    tick();
    q0_enq_valid = 1'b0;
    checks++;
    if (deq_src !== 1'b1 || deq_bits !== 32'h40) begin
      errors++;
      $display("FAIL stall_lock: got s%b bits %0h expected s1 bits 40", deq_src, deq_bits);
    end
    deq_ready = 1'b1;
    tick();
    checks++;
    if (deq_valid !== 1'b1 || deq_src !== 1'b0 || deq_bits !== 32'h50) begin
      errors++;
      $display("FAIL stall_next: got v%b s%b bits %0h expected v1 s0 bits 50",
               deq_valid, deq_src, deq_bits);
    end
    tick();
    deq_ready = 1'b0;
    tick();
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0_enq_valid = 1'b1;
      q0_enq_bits = 32'h60 + i;
      sb.push_back('{src: 1'b0, bits: 32'h60 + i});
      tick();
    end
    checks++;
    if (overflow !== 2'b00) begin
      errors++;
      $display("FAIL full_no_ovf: got %b expected 00", overflow);
    end
    deq_ready = 1'b1;
    q0_enq_bits = 32'h64;
    tick();
    q0_enq_valid = 1'b0;
    checks++;
    if (overflow !== 2'b01) begin
      errors++;
      $display("FAIL full_pushpop_ovf: got %b expected 01", overflow);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (deq_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_count: got %b expected 1 at beat %0d", deq_valid, i);
      end
      tick();
    end
    checks++;
    if (deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: got %b expected 0", deq_valid);
    end
    deq_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q0_enq_valid = 1'b1;
      q1_enq_valid = 1'b1;
      q0_enq_bits = 32'h70 + i;
      q1_enq_bits = 32'h80 + i;
      tick();
    end
    q0_enq_valid = 1'b0;
    q1_enq_valid = 1'b0;
    tick();
    checks++;
    if (deq_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got %b expected 1", deq_valid);
    end
    reset = 1'b1;
    q0_enq_valid = 1'b1;
    q1_enq_valid = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    q0_enq_valid = 1'b0;
    q1_enq_valid = 1'b0;
    checks++;
    if (deq_valid !== 1'b0 || deq_src !== 1'b0 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got v%b s%b ov%b expected v0 s0 ov00",
               deq_valid, deq_src, overflow);
    end
    tick();
    tick();
    checks++;
    if (deq_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_ignored_push: got %b expected 0", deq_valid);
    end
    q1_enq_valid = 1'b1;
    q1_enq_bits = 32'h90;
    sb.push_back('{src: 1'b1, bits: 32'h90});
    tick();
    q1_enq_valid = 1'b0;
    checks++;
    if (deq_valid !== 1'b1 || deq_src !== 1'b1 || deq_bits !== 32'h90) begin
      errors++;
      $display("FAIL mid_after: got v%b s%b bits %0h expected v1 s1 bits 90",
               deq_valid, deq_src, deq_bits);
    end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    q0_enq_valid = 1'b0;
    q1_enq_valid = 1'b0;
    q0_enq_bits = '0;
    q1_enq_bits = '0;
    deq_ready = 1'b0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_stall();
    test_full_push_pop();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_queue_credit_drain.md
Name: dual_queue_credit_drain

Overview:
- Consumer end of a credit-managed, no-backpressure two-channel link.
- Upstream pushes into two queues without sampling ready; it relies on credits and must never push into a full queue.
- This block buffers both channels, merges them round-robin onto one ready/valid output, and returns one credit pulse per dequeued entry.
- It also flags any push into a full queue: the push is dropped and a sticky overflow bit is set.

Parameters:
- WIDTH, 32, payload width per entry.
- DEPTH, 4, entries per queue; power of 2, minimum 2. It also equals the producer's initial credit count.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- q0_enq_valid  input  1  push strobe, channel 0; there is no ready back to the producer.
- q0_enq_bits  input  WIDTH  payload, channel 0.
- q1_enq_valid  input  1  push strobe, channel 1.
- q1_enq_bits  input  WIDTH  payload, channel 1.
- deq_ready  input  1  downstream accept.
- deq_valid  output  1  output holds a valid entry.
- deq_bits  output  WIDTH  head entry of the granted queue.
- deq_src  output  1  granted channel: 0 or 1.
- q0_credit  output  1  one-cycle pulse, one credit returned to channel 0.
- q1_credit  output  1  one-cycle pulse, one credit returned to channel 1.
- overflow  output  2  sticky; bit n set when channel n pushed while its queue was full.

Behaviour:
- Per-queue state:
  - circular buffer of DEPTH entries;
  - read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits.
  - full is count==DEPTH; empty is count==0. Both are evaluated from the start-of-cycle count.
- Enqueue:
  - qN_enq_valid with !full: write entry at wptr, wptr+1.
  - qN_enq_valid with full: entry dropped, pointers unchanged, overflow[N] set to 1. This holds even if the same queue dequeues in that cycle; no bypass.
- Arbitration:
  - Registers: last (1 bit) and lock (1 bit), plus locked_src.
  - If lock=1, grant=locked_src.
  - Else if both queues non-empty, grant=~last.
  - Else grant = the single non-empty queue.
- Output:
  - deq_valid = granted queue non-empty.
  - deq_bits = head of granted queue, combinational from storage.
  - deq_src = grant.
  - Zero-cycle path from stored entry to output. Minimum enq-to-deq latency is 1 cycle: an entry written at edge k is visible after edge k.
- Handshake:
  - Fire = deq_valid & deq_ready.
  - On fire: rptr+1 and count-1 for the granted queue, last<=grant, lock<=0.
  - deq_valid & !deq_ready: lock<=1, locked_src<=grant. deq_bits and deq_src stay stable until fire.
  - Arbitration never switches mid-stall, and deq_valid never drops once asserted except on reset.
- Simultaneous push and pop on the same non-full queue: count unchanged, both pointers advance.
- Credits:
  - qN_credit is registered: high exactly one cycle after the edge on which a fire from queue N occurred.
  - At most one credit pulse per cycle in total.
- Count arithmetic: next_count = count + push_ok - pop. Never exceeds DEPTH, never underflows.
- Reset, applied at any time including mid-stall:
  - all counts, pointers, lock and overflow go to 0; last goes to 1, so channel 0 wins first;
  - deq_valid=0, deq_src=0, q0_credit=0, q1_credit=0, deq_bits don't-care;
  - buffered entries are discarded and no credits are returned for them;
  - pushes during reset are ignored.
- Overflow is cleared only by reset.

Test Plan:
- Reset, then push 0xA0 on q0 only with deq_ready=1 → deq_valid=1, deq_bits=0xA0, deq_src=0 one cycle later; q0_credit pulses one cycle after the fire; overflow=2'b00.
- Fill both queues, q0={0x10..0x13} and q1={0x20..0x23}, holding deq_ready=0, then set deq_ready=1 → output order 0x10,0x20,0x11,0x21,0x12,0x22,0x13,0x23 on consecutive cycles; 8 credit pulses alternating q0/q1.
- Five pushes to q1 with deq_ready=0, DEPTH=4 → fifth entry dropped, overflow=2'b10. Drain yields exactly 4 entries; overflow stays 2'b10.
- q1 non-empty and granted with deq_ready=0 for 3 cycles, then push to q0 → deq_src holds 1 and deq_bits stable until fire; after the fire, q0 is granted next.
- q0 full, push and deq fire in the same cycle → push dropped, overflow[0]=1, count=3.
- Assert reset for 1 cycle while both queues are half full and the output is stalled → deq_valid=0, no credit pulses, overflow=0. A subsequent single push on q1 appears with deq_src=1.
